// File: rtl/bus_mem_responder.sv
// Memory-side responder for the 64-bit tagged request/response bus: line writes and latency-delayed read bursts.
// Optional write acknowledge beat enabled by defining BUS_MEM_RESPONDER_WRITE_ACK_EN.
module bus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int BURST_LEN      = 8,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    output logic                      busy
);

    localparam int ADDR_W = $clog2(MEM_WORDS);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(READ_LATENCY - 1);

`ifdef BUS_MEM_RESPONDER_WRITE_ACK_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        RD_WAIT  = 3'd2,
        RD_BURST = 3'd3,
        WR_ACK   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_DATA  = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } state_t;
`endif

    state_t                    state_r;
    logic [ADDR_W-1:0]         base_r;
    logic [BUS_TAG_WIDTH-1:0]  tag_r;
    logic [BEAT_W-1:0]         beat_r;
    logic [LAT_W-1:0]          wait_r;
    logic                      reqack_r;
    logic                      respcyc_r;
    logic [BUS_DATA_WIDTH-1:0] resp_r;
    logic [BUS_TAG_WIDTH-1:0]  resptag_r;
    logic                      busy_r;

    logic [BUS_DATA_WIDTH-1:0] mem_r [MEM_WORDS];

    logic [ADDR_W-1:0] hdr_base_s;
    logic [ADDR_W-1:0] beat_addr_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              wr_en_s;

    // Line-aligned word index; upper address bits fall off so accesses wrap around the array.
    assign hdr_base_s  = {bus_req[ADDR_W+2:3+BEAT_W], {BEAT_W{1'b0}}};
    assign beat_addr_s = base_r + ADDR_W'(beat_r);
    assign next_addr_s = beat_addr_s + ADDR_W'(1);

    // Write strobe: a data beat is consumed only on cycles that did not just ack.
    always_comb begin
        wr_en_s = 1'b0;
        if (!reset && (state_r == WR_DATA) && bus_reqcyc && !reqack_r) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Word array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[beat_addr_s] <= bus_req;
        end
    end

    // Transaction FSM with registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            base_r    <= {ADDR_W{1'b0}};
            tag_r     <= {BUS_TAG_WIDTH{1'b0}};
            beat_r    <= {BEAT_W{1'b0}};
            wait_r    <= {LAT_W{1'b0}};
            reqack_r  <= 1'b0;
            respcyc_r <= 1'b0;
            resp_r    <= {BUS_DATA_WIDTH{1'b0}};
            resptag_r <= {BUS_TAG_WIDTH{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            reqack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus_reqcyc && !reqack_r) begin
                        base_r   <= hdr_base_s;
                        tag_r    <= bus_reqtag;
                        beat_r   <= {BEAT_W{1'b0}};
                        wait_r   <= {LAT_W{1'b0}};
                        reqack_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= bus_reqtag[BUS_TAG_WIDTH-1] ? WR_DATA : RD_WAIT;
                    end
                end
                WR_DATA: begin
                    if (wr_en_s) begin
                        reqack_r <= 1'b1;
                        beat_r   <= beat_r + BEAT_W'(1);
                        if (beat_r == LAST_BEAT) begin
`ifdef BUS_MEM_RESPONDER_WRITE_ACK_EN
                            state_r   <= WR_ACK;
                            respcyc_r <= 1'b1;
                            resp_r    <= {BUS_DATA_WIDTH{1'b0}};
                            resptag_r <= tag_r;
`else
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
`endif
                        end
                    end
                end
                RD_WAIT: begin
                    if (wait_r == LAST_WAIT) begin
                        state_r   <= RD_BURST;
                        respcyc_r <= 1'b1;
                        resp_r    <= mem_r[beat_addr_s];
                        resptag_r <= tag_r;
                    end else begin
                        wait_r <= wait_r + LAT_W'(1);
                    end
                end
                RD_BURST: begin
                    if (bus_respack) begin
                        beat_r <= beat_r + BEAT_W'(1);
                        if (beat_r == LAST_BEAT) begin
                            respcyc_r <= 1'b0;
                            busy_r    <= 1'b0;
                            state_r   <= IDLE;
                        end else begin
                            resp_r <= mem_r[next_addr_s];
                        end
                    end
                end
`ifdef BUS_MEM_RESPONDER_WRITE_ACK_EN
                WR_ACK: begin
                    if (bus_respack) begin
                        respcyc_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
`endif
                default: begin
                    state_r   <= IDLE;
                    respcyc_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_reqack  = reqack_r;
    assign bus_respcyc = respcyc_r;
    assign bus_resp    = resp_r;
    assign bus_resptag = resptag_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized self-checking bench for bus_mem_responder against a line-level memory model.
module tb_bus_mem_responder;

    localparam int MEM_WORDS    = 4096;
    localparam int BURST_LEN    = 8;
    localparam int READ_LATENCY = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;
    logic [63:0] model [MEM_WORDS];
    logic [63:0] wdata [BURST_LEN];
    logic [63:0] written_q [$];
    time t_last_beat;
    time t_hdr_ack;

    always #5 clk = ~clk;

    bus_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .busy        (busy)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First word of the 64-byte line, after wrapping the line number into the array.
    function automatic int line_base(input logic [63:0] addr);
        return int'((addr / 64'd64) % 64'(MEM_WORDS / BURST_LEN)) * BURST_LEN;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [12:0] t, input int budget, output bit ok);
        bus_reqcyc = 1'b1;
        bus_req    = d;
        bus_reqtag = t;
        ok         = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (bus_reqack === 1'b1) ok = 1'b1;
        end
        bus_reqcyc = 1'b0;
        if (ok) ack_cnt++;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input bit gaps, input bit watch);
        bit ok;
        bit seen;
        int base;
        base = line_base(addr);
        send_beat(addr, tag, 20, ok);
        check_eq("wr_hdr_ack", 64'(ok), 64'd1);
        for (int k = 0; k < BURST_LEN; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
            send_beat(wdata[k], tag, 20, ok);
            check_eq("wr_beat_ack", 64'(ok), 64'd1);
        end
        for (int k = 0; k < BURST_LEN; k++) model[base + k] = wdata[k];
        written_q.push_back(addr);
        seen = 1'b0;
`ifdef BUS_MEM_RESPONDER_WRITE_ACK_EN
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus_respcyc === 1'b1) seen = 1'b1;
            else step();
        end
        check_eq("wr_resp_seen", 64'(seen), 64'd1);
        check_eq("wr_resp_tag", 64'(bus_resptag), 64'(tag));
        check_eq("wr_resp_data", bus_resp, 64'd0);
        bus_respack = 1'b1;
        step();
        bus_respack = 1'b0;
        check_eq("wr_resp_drop", 64'(bus_respcyc), 64'd0);
`else
        if (watch) begin
            for (int i = 0; i < 10; i++) begin
                step();
                if (bus_respcyc !== 1'b0) seen = 1'b1;
            end
            check_eq("wr_no_resp", 64'(seen), 64'd0);
        end
`endif
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input bit skip_hdr,
                           input int stall_beat, input int stall_len, input bit rnd_bp);
        bit ok;
        int lat;
        int base;
        logic [63:0] held;
        base = line_base(addr);
        if (!skip_hdr) begin
            send_beat(addr, tag, 20, ok);
            check_eq("rd_hdr_ack", 64'(ok), 64'd1);
        end
        check_eq("rd_busy", 64'(busy), 64'd1);
        lat = 0;
        // Acks while no beat is valid must be ignored.
        while (bus_respcyc !== 1'b1 && lat < 50) begin
            bus_respack = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        bus_respack = 1'b0;
        check_eq("rd_latency", 64'(lat), 64'(READ_LATENCY));
        for (int k = 0; k < BURST_LEN; k++) begin
            check_eq("rd_valid", 64'(bus_respcyc), 64'd1);
            check_eq("rd_data", bus_resp, model[base + k]);
            check_eq("rd_tag", 64'(bus_resptag), 64'(tag));
            if (k == stall_beat) begin
                held = bus_resp;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    check_eq("rd_hold", bus_resp, held);
                end
                check_eq("rd_hold_valid", 64'(bus_respcyc), 64'd1);
            end else if (rnd_bp && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) step();
            end
            bus_respack = 1'b1;
            step();
            bus_respack = 1'b0;
        end
        t_last_beat = $time;
        check_eq("rd_end", 64'(bus_respcyc), 64'd0);
    endtask

    initial begin
        bit ok;
        bit ok2;
        bit seen;
        int ack0;
        logic [63:0] a;

        for (int i = 0; i < MEM_WORDS; i++) model[i] = 64'd0;
        reset       = 1'b1;
        bus_reqcyc  = 1'b1;
        bus_req     = 64'd0;
        bus_reqtag  = 13'h0000;
        bus_respack = 1'b0;

        // Reset held with a pending header: nothing acked, all outputs quiet.
        repeat (3) begin
            step();
            check_eq("rst_ctrl", {48'd0, bus_reqack, bus_respcyc, busy, bus_resptag}, 64'd0);
            check_eq("rst_resp", bus_resp, 64'd0);
        end
        reset = 1'b0;
        step();
        check_eq("rst_hdr_ack", 64'(bus_reqack), 64'd1);
        bus_reqcyc = 1'b0;

        // Abort the resulting read mid-burst with reset.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus_respcyc === 1'b1) seen = 1'b1;
            else step();
        end
        check_eq("abort_first_beat", 64'(seen), 64'd1);
        bus_respack = 1'b1;
        step();
        bus_respack = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("abort_quiet", {62'd0, bus_respcyc, busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus_respcyc !== 1'b0) seen = 1'b1;
        end
        check_eq("abort_no_beats", 64'(seen), 64'd0);

        // Directed write then read-back.
        for (int k = 0; k < BURST_LEN; k++) wdata[k] = 64'hA0 + 64'(k);
        ack0 = ack_cnt;
        do_write(64'h1040, 13'h1005, 1'b0, 1'b1);
        check_eq("wr_ack_count", 64'(ack_cnt - ack0), 64'd9);
        do_read(64'h1040, 13'h0006, 1'b0, -1, 0, 1'b0);
        check_eq("idle_after_rd", 64'(busy), 64'd0);

        // Backpressure on beat 3.
        do_read(64'h1040, 13'h0006, 1'b0, 3, 5, 1'b0);

        // Aliasing: 0x8040 and 0x0047 map to the same line.
        for (int k = 0; k < BURST_LEN; k++) wdata[k] = {$urandom, $urandom};
        do_write(64'h8040, 13'h1ABC, 1'b1, 1'b0);
        do_read(64'h0047, 13'h0011, 1'b0, -1, 0, 1'b0);

        // Single outstanding: a header during the burst waits for the burst to finish.
        ok2 = 1'b0;
        t_hdr_ack = 0;
        fork
            do_read(64'h1040, 13'h0021, 1'b0, -1, 0, 1'b1);
            begin
                for (int i = 0; i < 30 && bus_respcyc !== 1'b1; i++) step();
                send_beat(64'h8047, 13'h0022, 60, ok2);
                t_hdr_ack = $time;
            end
        join
        check_eq("so_hdr_ack", 64'(ok2), 64'd1);
        check_eq("so_after_burst", 64'(t_hdr_ack > t_last_beat), 64'd1);
        do_read(64'h8047, 13'h0022, 1'b1, -1, 0, 1'b0);

        // Random mix of writes and reads of previously written lines.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 0 || written_q.size() == 0) begin
                for (int k = 0; k < BURST_LEN; k++) wdata[k] = {$urandom, $urandom};
                a = {$urandom, $urandom};
                do_write(a, {1'b1, 12'($urandom)}, 1'b1, 1'b0);
            end else begin
                a = written_q[$urandom_range(0, written_q.size() - 1)];
                a = a + 64'($urandom_range(0, 63)) + 64'(MEM_WORDS * 8) * 64'($urandom_range(0, 7));
                do_read(a, {1'b0, 12'($urandom)}, 1'b0, $urandom_range(0, 9), $urandom_range(1, 4), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
